dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_timer.sv | 36 +++
 rtl/dmem_responder.sv | 88 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Purpose: address map and constants shared by the data-memory responder and its bench.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dmem_pkg;

  // Word addresses; RAM occupies [RAM_BASE, RAM_BASE + RAM_WORDS).
  localparam logic [31:0] RAM_BASE         = 32'h0000_0000;
  localparam logic [31:0] ADDR_TIMER_COUNT = 32'h0000_1000;
  localparam logic [31:0] ADDR_TIMER_CMP   = 32'h0000_1001;
  localparam logic [31:0] ADDR_STATUS      = 32'h0000_1002;
  localparam logic [31:0] ADDR_LED         = 32'h0000_1003;
  localparam logic [31:0] ADDR_ID          = 32'h0000_1004;

  localparam logic [31:0] ID_VALUE         = 32'h350D_0001;
  localparam logic [31:0] TIMER_CMP_RESET  = 32'hFFFF_FFFF;

endpackage

// File: rtl/dmem_timer.sv
// Purpose: free-running 32-bit timer with compare register and sticky MATCH flag.
// Latency: writes and MATCH set/clear take effect on the rising edge; outputs are registers.
// Backpressure: none, always accepts strobes.
// Ports: clock/reset (async active-low); wr_count/wr_cmp/wr_status decoded write strobes;
//        wdata store data; count/cmp/match current register values.
module dmem_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_count,
  input  logic        wr_cmp,
  input  logic        wr_status,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic        match
);
  import dmem_pkg::*;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      cmp   <= TIMER_CMP_RESET;
      match <= 1'b0;
    end else begin
      // A load replaces the increment for that cycle.
      count <= wr_count ? wdata : count + 32'd1;
      if (wr_cmp) cmp <= wdata;
      // Compare uses the pre-increment count and pre-write cmp; set wins over clear.
      if (count == cmp)
        match <= 1'b1;
      else if (wr_status && wdata[0])
        match <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Purpose: processor data-memory slave: word RAM plus timer, status, LED and ID registers.
// Latency: reads are combinational (zero cycles); writes land on the rising edge with wren=1.
// Backpressure: none, the block is always ready.
// Ports: clock/reset (async active-low); address_dmem word address; data store data;
//        wren write enable; q_dmem read data; led LED register; irq timer MATCH flag.
module dmem_responder #(
  parameter int RAM_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [15:0] led,
  output logic        irq
);
  import dmem_pkg::*;

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   mem [RAM_WORDS];
  logic          ram_hit;
  logic          ram_we;
  logic [AW-1:0] ram_idx;
  logic [15:0]   led_reg;
  logic [31:0]   tmr_count;
  logic [31:0]   tmr_cmp;
  logic          tmr_match;
  logic          wr_count;
  logic          wr_cmp;
  logic          wr_status;

  // Full 32-bit compare: no aliasing of RAM into upper address space.
  assign ram_hit = (address_dmem - RAM_BASE) < 32'(RAM_WORDS);
  assign ram_idx = address_dmem[AW-1:0];
  // RAM has no reset; gating with reset blocks writes while reset is held,
  // including one coincident with reset assertion.
  assign ram_we  = wren & reset & ram_hit;

  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_idx] <= data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      led_reg <= '0;
    else if (wren && address_dmem == ADDR_LED)
      led_reg <= data[15:0];
  end

  assign wr_count  = wren && (address_dmem == ADDR_TIMER_COUNT);
  assign wr_cmp    = wren && (address_dmem == ADDR_TIMER_CMP);
  assign wr_status = wren && (address_dmem == ADDR_STATUS);

  dmem_timer u_timer (
    .clock     (clock),
    .reset     (reset),
    .wr_count  (wr_count),
    .wr_cmp    (wr_cmp),
    .wr_status (wr_status),
    .wdata     (data),
    .count     (tmr_count),
    .cmp       (tmr_cmp),
    .match     (tmr_match)
  );

  // Read mux sees register state before any write on this edge.
  always_comb begin
    q_dmem = '0;
    if (ram_hit) begin
      q_dmem = mem[ram_idx];
    end else begin
      case (address_dmem)
        ADDR_TIMER_COUNT: q_dmem = tmr_count;
        ADDR_TIMER_CMP:   q_dmem = tmr_cmp;
        ADDR_STATUS:      q_dmem = {31'd0, tmr_match};
        ADDR_LED:         q_dmem = {16'd0, led_reg};
        ADDR_ID:          q_dmem = ID_VALUE;
        default:          q_dmem = '0;
      endcase
    end
  end

  assign led = led_reg;
  assign irq = tmr_match;

endmodule
